// File: rtl/program_counter_pkg.sv
// rtl/program_counter_pkg.sv - FSM state encodings shared by the program counter slice
package program_counter_pkg;

  localparam int PC_STATE_BIT_NUM = 2;

  typedef enum logic [PC_STATE_BIT_NUM-1:0] {
    PC_STATE_IDLE = 2'd0,
    PC_STATE_RUN  = 2'd1,
    PC_STATE_STEP = 2'd2
  } pc_state_e;

endpackage

// File: rtl/program_counter_return_stack.sv
// rtl/program_counter_return_stack.sv - return-address LIFO with full/empty and sticky error
module return_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             full,
  output logic             empty,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      depth;
  logic [AW-1:0]    top_idx;

  assign full     = (depth == (AW+1)'(DEPTH));
  assign empty    = (depth == '0);
  // Low bits wrap to the last slot when the stack is full.
  assign top_idx  = depth[AW-1:0] - AW'(1);
  assign top_data = mem[top_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      depth <= '0;
      err   <= 1'b0;
    end else begin
      if (push && !full) begin
        depth <= depth + (AW+1)'(1);
      end else if (pop && !empty) begin
        depth <= depth - (AW+1)'(1);
      end
      if ((push && full) || (pop && empty)) begin
        err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[depth[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/program_counter.sv
// rtl/program_counter.sv - PC with run/step/idle gating; PC_CALL_STACK_EN adds the return stack
module program_counter
  import program_counter_pkg::*;
#(
  parameter int                  PC_WIDTH     = 16,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                  STACK_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                step,
  input  logic                pc_load_en,
  input  logic [PC_WIDTH-1:0] load_addr,
  input  logic                call_en,
  input  logic                ret_en,
  output logic [PC_WIDTH-1:0] pc,
  output logic                running,
  output logic                stack_full,
  output logic                stack_empty,
  output logic                stack_err
);

  pc_state_e           state, state_next;
  logic                advance;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] pc_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= PC_STATE_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      PC_STATE_IDLE: begin
        if (run)       state_next = PC_STATE_RUN;
        else if (step) state_next = PC_STATE_STEP;
      end
      PC_STATE_RUN:  if (!run) state_next = PC_STATE_IDLE;
      PC_STATE_STEP: state_next = PC_STATE_IDLE;
      default:       state_next = PC_STATE_IDLE;
    endcase
  end

  always_comb begin
    running = (state == PC_STATE_RUN) || (state == PC_STATE_STEP);
    advance = running;
  end

  assign pc_inc = pc + PC_WIDTH'(1);

`ifdef PC_CALL_STACK_EN
  logic                rs_push, rs_pop, rs_err;
  logic [PC_WIDTH-1:0] rs_top;
  logic                illegal, illegal_err;

  always_comb begin
    pc_next = pc_inc;
    rs_push = 1'b0;
    rs_pop  = 1'b0;
    illegal = 1'b0;
    if (advance) begin
      if (call_en && ret_en) begin
        illegal = 1'b1;
      end else if (ret_en) begin
        // Underflow is flagged inside the stack; the PC just falls through.
        rs_pop = 1'b1;
        if (!stack_empty) pc_next = rs_top;
      end else if (call_en) begin
        rs_push = 1'b1;
        pc_next = load_addr;
      end else if (pc_load_en) begin
        pc_next = load_addr;
      end
    end
  end

  return_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_return_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rs_push),
    .pop       (rs_pop),
    .push_data (pc_inc),
    .top_data  (rs_top),
    .full      (stack_full),
    .empty     (stack_empty),
    .err       (rs_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_err <= 1'b0;
    end else if (illegal) begin
      illegal_err <= 1'b1;
    end
  end

  assign stack_err = illegal_err | rs_err;
`else
  wire unused_stack = &{1'b0, call_en, ret_en, STACK_DEPTH[0]};

  always_comb begin
    pc_next = pc_load_en ? load_addr : pc_inc;
  end

  assign stack_full  = 1'b0;
  assign stack_empty = 1'b1;
  assign stack_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_VECTOR;
    end else if (advance) begin
      pc <= pc_next;
    end
  end

endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - directed checks of program_counter, expectations follow PC_CALL_STACK_EN
module tb_program_counter;

`ifdef PC_CALL_STACK_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic        pc_load_en = 1'b0;
  logic [15:0] load_addr = '0;
  logic        call_en = 1'b0;
  logic        ret_en = 1'b0;
  logic [15:0] pc;
  logic        running, stack_full, stack_empty, stack_err;

  int checks = 0;
  int errors = 0;

  program_counter #(
    .PC_WIDTH     (16),
    .RESET_VECTOR (16'h0000),
    .STACK_DEPTH  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .step        (step),
    .pc_load_en  (pc_load_en),
    .load_addr   (load_addr),
    .call_en     (call_en),
    .ret_en      (ret_en),
    .pc          (pc),
    .running     (running),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_err   (stack_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; step = 1'b0; pc_load_en = 1'b0;
    call_en = 1'b0; ret_en = 1'b0; load_addr = '0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic start_and_run_to(input logic [15:0] target);
    run = 1'b1;
    tick();
    while (pc != target) tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (pc !== 16'h0000 || running !== 1'b0 || stack_full !== 1'b0 ||
        stack_empty !== 1'b1 || stack_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: pc=%h run=%b full=%b empty=%b err=%b required 0000 0 0 1 0",
               pc, running, stack_full, stack_empty, stack_err);
    end
  endtask

  task automatic test_run();
    do_reset();
    run = 1'b1;
    tick();
    checks++;
    if (pc !== 16'h0000 || running !== 1'b1) begin
      errors++;
      $display("FAIL run_enter: pc=%h running=%b required 0000 1", pc, running);
    end
    step = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (pc !== 16'(i)) begin
        errors++;
        $display("FAIL run_count: pc=%h required %h", pc, 16'(i));
      end
    end
    step = 1'b0;
  endtask

  task automatic test_load();
    do_reset();
    start_and_run_to(16'h0003);
    pc_load_en = 1'b1; load_addr = 16'h0040;
    tick();
    checks++;
    if (pc !== 16'h0040) begin
      errors++;
      $display("FAIL load_branch: pc=%h required 0040", pc);
    end
    pc_load_en = 1'b0;
    tick();
    checks++;
    if (pc !== 16'h0041) begin
      errors++;
      $display("FAIL load_after: pc=%h required 0041", pc);
    end
    run = 1'b0;
    tick(); tick();
    checks++;
    if (pc !== 16'h0042 || running !== 1'b0) begin
      errors++;
      $display("FAIL run_stop: pc=%h running=%b required 0042 0", pc, running);
    end
  endtask

  task automatic test_step();
    do_reset();
    start_and_run_to(16'h0006);
    run = 1'b0;
    tick();
    tick();
    checks++;
    if (pc !== 16'h0007 || running !== 1'b0) begin
      errors++;
      $display("FAIL step_idle: pc=%h running=%b required 0007 0", pc, running);
    end
    pc_load_en = 1'b1; load_addr = 16'h1234;
    tick();
    checks++;
    if (pc !== 16'h0007) begin
      errors++;
      $display("FAIL idle_load_ignored: pc=%h required 0007", pc);
    end
    pc_load_en = 1'b0; step = 1'b1;
    tick();
    step = 1'b0;
    checks++;
    if (pc !== 16'h0007 || running !== 1'b1) begin
      errors++;
      $display("FAIL step_enter: pc=%h running=%b required 0007 1", pc, running);
    end
    tick();
    checks++;
    if (pc !== 16'h0008 || running !== 1'b0) begin
      errors++;
      $display("FAIL step_once: pc=%h running=%b required 0008 0", pc, running);
    end
    tick(); tick();
    checks++;
    if (pc !== 16'h0008) begin
      errors++;
      $display("FAIL step_hold: pc=%h required 0008", pc);
    end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    run = 1'b1;
    tick();
    pc_load_en = 1'b1; load_addr = 16'hFFFF;
    tick();
    pc_load_en = 1'b0;
    tick();
    checks++;
    if (pc !== 16'h0000) begin
      errors++;
      $display("FAIL wrap: pc=%h required 0000", pc);
    end
    tick(); tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (pc !== 16'h0000 || running !== 1'b0) begin
      errors++;
      $display("FAIL mid_run_reset: pc=%h running=%b required 0000 0", pc, running);
    end
    rst_n = 1'b1; run = 1'b0;
  endtask

  task automatic test_call_ret();
    do_reset();
    start_and_run_to(16'h0005);
    call_en = 1'b1; load_addr = 16'h0020;
    tick();
    call_en = 1'b0;
    checks++;
    if (pc !== (EN ? 16'h0020 : 16'h0006) || stack_empty !== !EN) begin
      errors++;
      $display("FAIL call: pc=%h empty=%b required %h %b", pc, stack_empty,
               EN ? 16'h0020 : 16'h0006, !EN);
    end
    tick(); tick();
    ret_en = 1'b1;
    tick();
    ret_en = 1'b0;
    checks++;
    if (pc !== (EN ? 16'h0006 : 16'h0009) || stack_empty !== 1'b1 || stack_err !== 1'b0) begin
      errors++;
      $display("FAIL ret: pc=%h empty=%b err=%b required %h 1 0", pc, stack_empty, stack_err,
               EN ? 16'h0006 : 16'h0009);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] pops [4];
    pops[0] = 16'h0101; pops[1] = 16'h0101; pops[2] = 16'h0101; pops[3] = 16'h0001;
    do_reset();
    run = 1'b1;
    tick();
    call_en = 1'b1; load_addr = 16'h0100;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (pc !== (EN ? 16'h0100 : 16'(i)) || stack_full !== (EN && i >= 4) ||
          stack_err !== (EN && i == 5)) begin
        errors++;
        $display("FAIL overflow_call%0d: pc=%h full=%b err=%b required %h %b %b", i, pc,
                 stack_full, stack_err, EN ? 16'h0100 : 16'(i), EN && i >= 4, EN && i == 5);
      end
    end
    call_en = 1'b0; ret_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (pc !== (EN ? pops[i] : 16'(6 + i))) begin
        errors++;
        $display("FAIL pop%0d: pc=%h required %h", i, pc, EN ? pops[i] : 16'(6 + i));
      end
    end
    tick();
    ret_en = 1'b0;
    checks++;
    if (pc !== (EN ? 16'h0002 : 16'h000A) || stack_empty !== 1'b1 || stack_err !== EN) begin
      errors++;
      $display("FAIL pop_empty: pc=%h empty=%b err=%b required %h 1 %b", pc, stack_empty,
               stack_err, EN ? 16'h0002 : 16'h000A, EN);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    run = 1'b1;
    tick();
    ret_en = 1'b1;
    tick();
    ret_en = 1'b0;
    checks++;
    if (pc !== 16'h0001 || stack_empty !== 1'b1 || stack_err !== EN) begin
      errors++;
      $display("FAIL underflow: pc=%h empty=%b err=%b required 0001 1 %b", pc, stack_empty,
               stack_err, EN);
    end
    tick();
    checks++;
    if (stack_err !== EN) begin
      errors++;
      $display("FAIL err_sticky: err=%b required %b", stack_err, EN);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    start_and_run_to(16'h0009);
    call_en = 1'b1; ret_en = 1'b1; load_addr = 16'h0055;
    tick();
    call_en = 1'b0; ret_en = 1'b0;
    checks++;
    if (pc !== 16'h000A || stack_empty !== 1'b1 || stack_err !== EN) begin
      errors++;
      $display("FAIL illegal: pc=%h empty=%b err=%b required 000a 1 %b", pc, stack_empty,
               stack_err, EN);
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_load();
    test_step();
    test_wrap_and_reset();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
